hit_response: RTL and testbench

Defender-side reaction controller for one fighter. It consumes the per-frame `hit`/`block` strobes produced by the attack logic and turns them into health loss, hitstun/blockstun timing, and a knockback velocity. It also detects knockout. One instance exists per player. Its outputs feed the fighter motion controller (knockback, stun lockout) and the HUD (health, KO).

---
 rtl/hit_response_if.sv | 40 ++++
 rtl/hit_response.sv | 155 +++++++++++++++
 tb/tb_hit_response.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_response_if.sv
// Bundles the per-frame strobes into hit_response and the reaction outputs it returns.
// The controller uses the slave modport; the attack logic, motion controller and HUD use the master modport.
interface hit_response_if;
    logic               round_start;
    logic               hit_in;
    logic               block_in;
    logic               attacker_left;
    logic [7:0]         health;
    logic               stunned;
    logic               blocking;
    logic               ko;
    logic               damage_pulse;
    logic signed [31:0] knockback;

    modport slave (
        input  round_start,
        input  hit_in,
        input  block_in,
        input  attacker_left,
        output health,
        output stunned,
        output blocking,
        output ko,
        output damage_pulse,
        output knockback
    );

    modport master (
        output round_start,
        output hit_in,
        output block_in,
        output attacker_left,
        input  health,
        input  stunned,
        input  blocking,
        input  ko,
        input  damage_pulse,
        input  knockback
    );
endinterface

// File: rtl/hit_response.sv
// Defender-side reaction controller: converts hit/block strobes into health loss, stun timing and knockback.
// Optional feature: define HIT_CHIP_DAMAGE_EN so that blocked attacks also cost CHIP_DAMAGE health.
module hit_response #(
    parameter int MAX_HEALTH        = 100,
    parameter int HIT_DAMAGE        = 10,
    parameter int CHIP_DAMAGE       = 2,
    parameter int HITSTUN_FRAMES    = 20,
    parameter int BLOCKSTUN_FRAMES  = 10,
    parameter int KNOCK_SPEED       = 4,
    parameter int BLOCK_KNOCK_SPEED = 2
) (
    input  logic           frame_clk,
    input  logic           Reset,
    hit_response_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        HITSTUN,
        BLOCKSTUN,
        KO
    } state_t;

    localparam logic [7:0] HEALTH_INIT  = 8'(MAX_HEALTH);
    localparam logic [7:0] HIT_DMG      = 8'(HIT_DAMAGE);
    localparam logic [7:0] HIT_CNT_INIT = 8'(HITSTUN_FRAMES - 1);
    localparam logic [7:0] BLK_CNT_INIT = 8'(BLOCKSTUN_FRAMES - 1);
    localparam logic signed [31:0] HIT_KB = 32'(KNOCK_SPEED);
    localparam logic signed [31:0] BLK_KB = 32'(BLOCK_KNOCK_SPEED);

`ifdef HIT_CHIP_DAMAGE_EN
    localparam logic [7:0] BLOCK_DMG = 8'(CHIP_DAMAGE);
`else
    // A block still runs through the subtractor, just with a zero amount.
    localparam logic [7:0] BLOCK_DMG = 8'(CHIP_DAMAGE * 0);
`endif

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         health_q, health_d;
    logic               dir_q, dir_d;
    logic               pulse_q, pulse_d;
    logic               stunned_q, stunned_d;
    logic               blocking_q, blocking_d;
    logic               ko_q, ko_d;
    logic signed [31:0] knock_q, knock_d;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? 8'd0 : diff[7:0];
    endfunction

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            health_q   <= HEALTH_INIT;
            dir_q      <= 1'b0;
            pulse_q    <= 1'b0;
            stunned_q  <= 1'b0;
            blocking_q <= 1'b0;
            ko_q       <= 1'b0;
            knock_q    <= 32'sd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            health_q   <= health_d;
            dir_q      <= dir_d;
            pulse_q    <= pulse_d;
            stunned_q  <= stunned_d;
            blocking_q <= blocking_d;
            ko_q       <= ko_d;
            knock_q    <= knock_d;
        end
    end

    // Stun states ignore both strobes; a strobe still held on the first IDLE frame counts as new.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        health_d = health_q;
        dir_d    = dir_q;
        pulse_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hit_in) begin
                    health_d = sat_sub(health_q, HIT_DMG);
                    pulse_d  = 1'b1;
                    if (health_d == 8'd0) begin
                        state_d = KO;
                    end else begin
                        state_d = HITSTUN;
                        cnt_d   = HIT_CNT_INIT;
                        dir_d   = bus.attacker_left;
                    end
                end else if (bus.block_in) begin
                    health_d = sat_sub(health_q, BLOCK_DMG);
                    state_d  = BLOCKSTUN;
                    cnt_d    = BLK_CNT_INIT;
                    dir_d    = bus.attacker_left;
`ifdef HIT_CHIP_DAMAGE_EN
                    pulse_d  = 1'b1;
                    if (health_d == 8'd0) begin
                        state_d = KO;
                        cnt_d   = 8'd0;
                    end
`endif
                end
            end
            HITSTUN, BLOCKSTUN: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            KO: begin
                health_d = 8'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.round_start) begin
            state_d  = IDLE;
            cnt_d    = 8'd0;
            health_d = HEALTH_INIT;
            pulse_d  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        stunned_d  = (state_d == HITSTUN);
        blocking_d = (state_d == BLOCKSTUN);
        ko_d       = (state_d == KO);
        knock_d    = 32'sd0;
        if (state_d == HITSTUN) begin
            knock_d = dir_d ? HIT_KB : -HIT_KB;
        end else if (state_d == BLOCKSTUN) begin
            knock_d = dir_d ? BLK_KB : -BLK_KB;
        end
    end

    assign bus.health       = health_q;
    assign bus.stunned      = stunned_q;
    assign bus.blocking     = blocking_q;
    assign bus.ko           = ko_q;
    assign bus.damage_pulse = pulse_q;
    assign bus.knockback    = knock_q;

endmodule

// File: tb/tb_hit_response.sv
// Self-checking bench for hit_response: a default instance plus a MAX_HEALTH=15 instance share one stimulus
// stream and are compared every frame against a frame-level reaction model.
module tb_hit_response;

`ifdef HIT_CHIP_DAMAGE_EN
    localparam bit CHIP_EN = 1'b1;
`else
    localparam bit CHIP_EN = 1'b0;
`endif

    logic frame_clk = 1'b0;
    logic rst = 1'b1;
    logic rs = 1'b0;
    logic hit = 1'b0;
    logic blk = 1'b0;
    logic al = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    hit_response_if bus0 ();
    hit_response_if bus1 ();

    assign bus0.round_start   = rs;
    assign bus0.hit_in        = hit;
    assign bus0.block_in      = blk;
    assign bus0.attacker_left = al;
    assign bus1.round_start   = rs;
    assign bus1.hit_in        = hit;
    assign bus1.block_in      = blk;
    assign bus1.attacker_left = al;

    hit_response dut (
        .frame_clk (frame_clk),
        .Reset     (rst),
        .bus       (bus0)
    );

    hit_response #(.MAX_HEALTH(15)) dut_ko (
        .frame_clk (frame_clk),
        .Reset     (rst),
        .bus       (bus1)
    );

    // Reaction model: health, remaining stun frames and stun kind (0 none, 1 hit, 2 block).
    int m_health[2];
    int m_left[2];
    int m_kind[2];
    int m_dir[2];
    bit m_ko[2];
    bit m_pulse[2];
    bit model_valid = 1'b0;

    function automatic int cfgMax(input int i);
        return (i == 0) ? 100 : 15;
    endfunction

    function automatic int floorZero(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic modelRestart(input int i);
        m_health[i] = cfgMax(i);
        m_left[i]   = 0;
        m_kind[i]   = 0;
        m_ko[i]     = 1'b0;
        m_pulse[i]  = 1'b0;
        m_dir[i]    = 1;
    endtask

    task automatic modelStep(input int i);
        m_pulse[i] = 1'b0;
        if (rst || rs) begin
            modelRestart(i);
        end else if (m_ko[i]) begin
            m_health[i] = 0;
        end else if (m_kind[i] != 0) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_kind[i] = 0;
        end else if (hit) begin
            m_health[i] = floorZero(m_health[i] - 10);
            m_pulse[i]  = 1'b1;
            if (m_health[i] == 0) begin
                m_ko[i] = 1'b1;
            end else begin
                m_kind[i] = 1;
                m_left[i] = 20;
                m_dir[i]  = al ? 1 : -1;
            end
        end else if (blk) begin
            if (CHIP_EN) begin
                m_health[i] = floorZero(m_health[i] - 2);
                m_pulse[i]  = 1'b1;
            end
            if (m_health[i] == 0) begin
                m_ko[i] = 1'b1;
            end else begin
                m_kind[i] = 2;
                m_left[i] = 10;
                m_dir[i]  = al ? 1 : -1;
            end
        end
    endtask

    always @(posedge frame_clk) begin
        for (int i = 0; i < 2; i++) modelStep(i);
        if (rst) model_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareInst(input int i, input logic [7:0] h, input logic st, input logic bl,
                               input logic k, input logic dp, input logic signed [31:0] kb);
        int exp_kb;
        exp_kb = (m_kind[i] == 1) ? m_dir[i] * 4 : (m_kind[i] == 2) ? m_dir[i] * 2 : 0;
        checkOutput($sformatf("inst%0d health", i), int'(h), m_health[i]);
        checkOutput($sformatf("inst%0d stunned", i), int'(st), int'(m_kind[i] == 1));
        checkOutput($sformatf("inst%0d blocking", i), int'(bl), int'(m_kind[i] == 2));
        checkOutput($sformatf("inst%0d ko", i), int'(k), int'(m_ko[i]));
        checkOutput($sformatf("inst%0d damage_pulse", i), int'(dp), int'(m_pulse[i]));
        checkOutput($sformatf("inst%0d knockback", i), int'(kb), exp_kb);
    endtask

    always @(negedge frame_clk) begin
        if (model_valid) begin
            compareInst(0, bus0.health, bus0.stunned, bus0.blocking, bus0.ko, bus0.damage_pulse, bus0.knockback);
            compareInst(1, bus1.health, bus1.stunned, bus1.blocking, bus1.ko, bus1.damage_pulse, bus1.knockback);
        end
    end

    // Drives one frame's worth of inputs at the falling edge and waits for the next falling edge.
    task automatic applyStimulus(input bit r, input bit s, input bit h, input bit b, input bit a, input int frames);
        rst = r;
        rs  = s;
        hit = h;
        blk = b;
        al  = a;
        repeat (frames) @(negedge frame_clk);
    endtask

    task automatic idleFrames(input int frames);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, frames);
    endtask

    initial begin
        repeat (2) @(negedge frame_clk);
        idleFrames(1);
        checkOutput("reset health", int'(bus0.health), 100);
        checkOutput("reset knockback", int'(bus0.knockback), 0);
        checkOutput("reset ko15 health", int'(bus1.health), 15);

        // Basic hit from the left.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("hit health", int'(bus0.health), 90);
        checkOutput("hit pulse", int'(bus0.damage_pulse), 1);
        checkOutput("hit stunned", int'(bus0.stunned), 1);
        checkOutput("hit knockback", int'(bus0.knockback), 4);
        idleFrames(19);
        checkOutput("hit last stun frame", int'(bus0.stunned), 1);
        checkOutput("hit pulse gone", int'(bus0.damage_pulse), 0);
        idleFrames(1);
        checkOutput("hit stun over", int'(bus0.stunned), 0);
        checkOutput("hit idle knockback", int'(bus0.knockback), 0);

        // Held strobe: one hit per stun window, re-hit on the first idle frame.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("round health", int'(bus0.health), 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 21);
        checkOutput("held health during idle", int'(bus0.health), 90);
        checkOutput("held idle frame", int'(bus0.stunned), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("held rehit health", int'(bus0.health), 80);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        idleFrames(20);

        // Block from the right.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("block blocking", int'(bus0.blocking), 1);
        checkOutput("block knockback", int'(bus0.knockback), -2);
        checkOutput("block health", int'(bus0.health), CHIP_EN ? 98 : 100);
        idleFrames(9);
        checkOutput("block last frame", int'(bus0.blocking), 1);
        idleFrames(1);
        checkOutput("block over", int'(bus0.blocking), 0);

        // Simultaneous hit and block.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        checkOutput("both health", int'(bus0.health), 90);
        checkOutput("both stunned", int'(bus0.stunned), 1);
        checkOutput("both blocking", int'(bus0.blocking), 0);
        idleFrames(20);

        // KO on the 15-health instance.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("ko first hit", int'(bus1.health), 5);
        idleFrames(20);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("ko health", int'(bus1.health), 0);
        checkOutput("ko flag", int'(bus1.ko), 1);
        checkOutput("ko knockback", int'(bus1.knockback), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5);
        checkOutput("ko ignores hits", int'(bus1.ko), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("ko round health", int'(bus1.health), 15);
        checkOutput("ko round flag", int'(bus1.ko), 0);
        checkOutput("round beats hit", int'(bus1.stunned), 0);

        // Reset on the fifth stun frame.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        idleFrames(4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("reset mid-stun stunned", int'(bus0.stunned), 0);
        checkOutput("reset mid-stun health", int'(bus0.health), 100);
        checkOutput("reset mid-stun knockback", int'(bus0.knockback), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 99) == 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 5) == 0,
                          1'($urandom_range(0, 1)),
                          1);
        end

        idleFrames(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
